// File: rtl/fpt_relay_uart_tx.sv
// Telemetry transmitter: captures an FPT core snapshot and sends it as a
// 5-byte checksummed 8N1 UART frame (sync, seq/flags, corr hi, corr lo, xor).
module fpt_relay_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        snap_valid,
    output logic        snap_ready,
    input  logic [15:0] motor_correction,
    input  logic        veto,
    input  logic [1:0]  attention_level,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  seq_q, seq_d;
    logic [3:0]  frame_seq_q, frame_seq_d;
    logic [15:0] corr_q, corr_d;
    logic        veto_q, veto_d;
    logic [1:0]  att_q, att_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  cur_byte;
    logic        bit_done;

    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [3:0]  s,
        input logic        v,
        input logic [1:0]  a,
        input logic [15:0] c
    );
        logic [7:0] b1;
        b1 = {s, 1'b0, v, a};
        case (idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = c[15:8];
            3'd3:    frame_byte = c[7:0];
            default: frame_byte = b1 ^ c[15:8] ^ c[7:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        seq_d       = seq_q;
        frame_seq_d = frame_seq_q;
        corr_d      = corr_q;
        veto_d      = veto_q;
        att_d       = att_q;
        drop_d      = drop_q;
        tx_d        = 1'b1;
        cur_byte    = '0;
        bit_done    = (clk_cnt_q == LAST_CLK);

        case (state_q)
            IDLE: begin
                if (snap_valid) begin
                    corr_d      = motor_correction;
                    veto_d      = veto;
                    att_d       = attention_level;
                    frame_seq_d = seq_q;
                    clk_cnt_d   = '0;
                    bit_idx_d   = '0;
                    byte_idx_d  = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q < 3'd4) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end else begin
                        seq_d   = seq_q + 4'd1;
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so uart_tx is a flop output
        // that lines up exactly with the state register.
        cur_byte = frame_byte(byte_idx_d, frame_seq_d, veto_d, att_d, corr_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);

        if (snap_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            seq_q       <= '0;
            frame_seq_q <= '0;
            corr_q      <= '0;
            veto_q      <= 1'b0;
            att_q       <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            seq_q       <= seq_d;
            frame_seq_q <= frame_seq_d;
            corr_q      <= corr_d;
            veto_q      <= veto_d;
            att_q       <= att_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign uart_tx    = tx_q;
    assign snap_ready = ready_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fpt_relay_uart_tx.sv
// Directed bench for fpt_relay_uart_tx: decodes frames off the serial line
// at mid-bit and compares against hand-computed bytes.
module tb_fpt_relay_uart_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        snap_valid = 1'b0;
    logic [15:0] corr = '0;
    logic        veto = 1'b0;
    logic [1:0]  att = '0;
    logic        snap_ready;
    logic        uart_tx;
    logic        busy;
    logic [7:0]  drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rx_b [5];
    logic        frame_ok;
    int          busy_n;
    int          gap_n;

    fpt_relay_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk_100mhz       (clk),
        .rst_n            (rst_n),
        .snap_valid       (snap_valid),
        .snap_ready       (snap_ready),
        .motor_correction (corr),
        .veto             (veto),
        .attention_level  (att),
        .uart_tx          (uart_tx),
        .busy             (busy),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts on the first negedge where the line is low; returns on the
    // negedge of the last stop-bit cycle of byte 4.
    task automatic rx_frame(input string tag);
        int t;
        int n;
        logic [9:0] sh;
        frame_ok = 1'b1;
        n = 0;
        while (uart_tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) begin
            chk({tag, "_start_timeout"}, {31'd0, uart_tx}, 32'd0);
            for (int b = 0; b < 5; b++) rx_b[b] = '0;
            return;
        end
        t = 0;
        for (int b = 0; b < 5; b++) begin
            for (int p = 0; p < 10; p++) begin
                while (t < (b * 10 + p) * C + C / 2) begin
                    @(negedge clk);
                    t++;
                end
                sh[p] = uart_tx;
            end
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1) frame_ok = 1'b0;
            rx_b[b] = sh[8:1];
        end
        while (t < 50 * C - 1) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_framing"}, {31'd0, frame_ok}, 32'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        chk({tag, "_b0"}, {24'd0, rx_b[0]}, {24'd0, e0});
        chk({tag, "_b1"}, {24'd0, rx_b[1]}, {24'd0, e1});
        chk({tag, "_b2"}, {24'd0, rx_b[2]}, {24'd0, e2});
        chk({tag, "_b3"}, {24'd0, rx_b[3]}, {24'd0, e3});
        chk({tag, "_b4"}, {24'd0, rx_b[4]}, {24'd0, e4});
    endtask

    // Returns on the negedge just after the accepting edge.
    task automatic send_snap(input logic [15:0] c, input logic v, input logic [1:0] a);
        int n;
        @(negedge clk);
        corr = c;
        veto = v;
        att = a;
        snap_valid = 1'b1;
        n = 0;
        while (snap_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (snap_ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, snap_ready}, 32'd1);
            snap_valid = 1'b0;
            return;
        end
        @(negedge clk);
        snap_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, snap_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single frame, seq 0
        send_snap(16'h1234, 1'b1, 2'b10);
        chk("acc_tx", {31'd0, uart_tx}, 32'd0);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_ready", {31'd0, snap_ready}, 32'd0);
        busy_n = 0;
        fork
            rx_frame("single");
            begin
                while (busy === 1'b1 && busy_n < 1000) begin
                    busy_n++;
                    @(negedge clk);
                end
            end
        join
        chk_frame("single", 8'hA5, 8'h06, 8'h12, 8'h34, 8'h20);
        chk("busy_len", busy_n, 32'd200);
        chk("end_ready", {31'd0, snap_ready}, 32'd1);

        // Capture isolation and drop counting, seq 1
        send_snap(16'hBEEF, 1'b0, 2'b01);
        fork
            rx_frame("iso");
            begin
                repeat (30) @(negedge clk);
                corr = 16'h0000;
                veto = 1'b1;
                att = 2'b11;
                snap_valid = 1'b1;
                repeat (3) @(negedge clk);
                snap_valid = 1'b0;
            end
        join
        chk_frame("iso", 8'hA5, 8'h11, 8'hBE, 8'hEF, 8'h40);
        chk("drop3", {24'd0, drop_count}, 32'd3);
        wait_idle();

        // Back-to-back with valid held high
        do_reset();
        @(negedge clk);
        corr = 16'h00FF;
        veto = 1'b0;
        att = 2'b00;
        snap_valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            rx_frame("b2b");
            chk("b2b_seq", {24'd0, rx_b[1]}, 32'(f * 16));
            chk("b2b_ck", {24'd0, rx_b[4]}, 32'((f * 16) ^ 8'hFF));
            if (f < 2) begin
                gap_n = 0;
                @(negedge clk);
                while (uart_tx === 1'b1 && gap_n < 100) begin
                    gap_n++;
                    @(negedge clk);
                end
                chk("b2b_gap", gap_n, 32'd1);
            end else begin
                snap_valid = 1'b0;
            end
        end
        chk("drop_sat", {24'd0, drop_count}, 32'd255);
        wait_idle();

        // Saturation hold
        @(negedge clk);
        snap_valid = 1'b1;
        repeat (20) @(negedge clk);
        snap_valid = 1'b0;
        chk("drop_hold", {24'd0, drop_count}, 32'd255);
        wait_idle();

        // Seq wrap over 17 frames
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_snap(16'(i), 1'b0, 2'b00);
            if (i >= 15) begin
                rx_frame("wrap");
                chk("wrap_seq", {28'd0, rx_b[1][7:4]}, (i == 15) ? 32'd15 : 32'd0);
            end else begin
                wait_idle();
            end
        end
        wait_idle();

        // Reset mid-frame during data of byte 2 (0xC3, bit 2 is 0)
        send_snap(16'hC3C3, 1'b1, 2'b01);
        repeat (23 * C) @(negedge clk);
        chk("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_ready", {31'd0, snap_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx", {31'd0, uart_tx}, 32'd1);
        send_snap(16'h0102, 1'b0, 2'b10);
        rx_frame("post_rst");
        chk_frame("post_rst", 8'hA5, 8'h02, 8'h01, 8'h02, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpt_relay_uart_tx.md
# fpt_relay_uart_tx

Telemetry transmitter for the nRF swarm relay link. It captures a snapshot of the FPT core outputs (motor correction, veto, attention level) through a valid/ready handshake. It serialises the snapshot as a fixed 5-byte checksummed frame on an 8N1 UART line. It runs in the core clock domain, sits beside `psi_fpt_core`, and drives the board UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

- `clk_100mhz` in 1: core clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `snap_valid` in 1: snapshot offered this cycle.
- `snap_ready` out 1: block can accept a snapshot this cycle.
- `motor_correction` in 16: sampled when `snap_valid & snap_ready`.
- `veto` in 1: sampled with the snapshot.
- `attention_level` in 2: sampled with the snapshot.
- `uart_tx` out 1: serial line, idle high.
- `busy` out 1: frame in flight.
- `drop_count` out 8: saturating count of snapshots offered while not ready.

## Operation
- Frame layout, bytes in order:
  - B0 = `SYNC_BYTE`
  - B1 = {seq[3:0], 1'b0, veto, attention_level[1:0]}
  - B2 = corr[15:8]
  - B3 = corr[7:0]
  - B4 = B1^B2^B3
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1).
  - No idle gap between bytes; the next start bit follows the stop bit directly.
- FSM states:
  - IDLE: `snap_ready`=1, `uart_tx`=1. On `snap_valid` it latches all fields and the current seq, clears the bit counter, sets byte index to 0, and goes to START.
  - START: drives 0 for CLKS_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: drives byte[bit] for CLKS_PER_BIT cycles per bit. After bit 7 it goes to STOP.
  - STOP: drives 1 for CLKS_PER_BIT cycles. Then, if byte index < 4, it increments the index and goes to START. Otherwise it increments seq (mod 16) and goes to IDLE.
- `snap_ready` = (state==IDLE). `busy` = (state!=IDLE).
- Drop counting: a cycle with `snap_valid`=1 and `snap_ready`=0 increments `drop_count`.
  - The counter saturates at 255 and never wraps.
  - It is cleared only by reset.
- Captured fields are held internally. Input changes during a frame do not affect the bytes on the line.
- The checksum is computed from the latched values, never from live inputs.
- seq wraps from 15 to 0.

## Timing
- Reset values (applied asynchronously):
  - `uart_tx`=1, `snap_ready`=1, `busy`=0, `drop_count`=0.
  - seq=0, state IDLE.
- Acceptance: handshake at rising edge k. From edge k+1, `uart_tx`=0, `busy`=1 and `snap_ready`=0, all registered.
- Frame length is exactly 50·CLKS_PER_BIT cycles, measured from edge k+1 to the edge where the FSM re-enters IDLE.
  - `snap_ready` returns to 1 on that edge.
  - A back-to-back snapshot accepted on that edge starts its start bit one cycle later. This gives one cycle of idle high between frames.
- Each bit holds for exactly CLKS_PER_BIT cycles, with no drift across the frame.
- `snap_valid` in the same cycle as the IDLE re-entry edge is not accepted and is counted as a drop. Acceptance requires the registered `snap_ready`=1.
- Reset mid-frame:
  - `uart_tx` goes high immediately and the frame is abandoned; there is no partial-frame completion.
  - seq returns to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single frame with CLKS_PER_BIT=4: inputs corr=16'h1234, veto=1, att=2'b10, seq=0.
  - Decoded bytes must be A5, 06, 12, 34, 20.
  - Frame length is 200 cycles, and `busy` is high for exactly those 200 cycles.
- Back-to-back: `snap_valid` is held high for 3 frames with corr=0x00FF.
  - B1 seq fields must be 0, 1, 2.
  - Exactly one idle-high cycle separates consecutive frames.
- Drop and saturation: assert `snap_valid` for 3 cycles during a frame, then `drop_count`=3.
  - Continuous valid through a frame drives `drop_count` to 255, where it holds.
- Capture isolation: change corr from 0xBEEF to 0x0000 mid-frame. The frame must still carry BE, EF and checksum B1^BE^EF.
- Seq wrap: send 17 frames. The 17th frame must carry seq=0.
- Reset mid-frame: pull `rst_n` low during the DATA state of byte B2.
  - `uart_tx`=1 and `snap_ready`=1 must appear without waiting for a clock edge.
  - After release, the next frame carries seq=0.
